// File: rtl/mod_counter_n.sv
// Up/down modulo-(MAX+1) counter with variable step, wrap or saturate overflow
// handling, a one-cycle carry/borrow pulse and a sticky overflow flag.
module mod_counter_n #(
    parameter int N   = 11,
    parameter int S   = 1,
    parameter int MAX = 2**N - 1,
    parameter bit SAT = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
    input  logic [S-1:0] step,
    input  logic         clr,
    input  logic         ld,
    input  logic [N-1:0] ld_val,
    input  logic         ovf_clr,
    output logic [N-1:0] cnt,
    output logic         cout,
    output logic         ovf,
    output logic         zero,
    output logic         full
);

    // One extra bit so sums and MAX+1 never overflow the arithmetic.
    localparam int             W     = N + 1;
    localparam logic [N-1:0]   MAX_N = N'(MAX);
    localparam logic [W-1:0]   MAX_W = W'(MAX);
    localparam logic [W-1:0]   MOD_W = MAX_W + W'(1);

    logic [N-1:0] cnt_q, cnt_d;
    logic         cout_q, cout_d;
    logic         ovf_q, ovf_d;

    logic [W-1:0] cnt_w;
    logic [W-1:0] step_w;
    logic [W-1:0] step_m;
    logic [W-1:0] sum_raw;
    logic [W-1:0] sum_w;
    logic         up_evt;
    logic         dn_evt;
    logic [N-1:0] up_val;
    logic [N-1:0] dn_val;
    logic         ovf_set;

    // Events are judged on the raw step; the wrapped value uses step mod (MAX+1).
    always_comb begin
        cnt_w   = {1'b0, cnt_q};
        step_w  = W'(step);
        step_m  = step_w % MOD_W;
        sum_raw = cnt_w + step_w;
        sum_w   = cnt_w + step_m;
        up_evt  = (sum_raw > MAX_W);
        dn_evt  = (step_w > cnt_w);

        if (SAT && up_evt) begin
            up_val = MAX_N;
        end else if (sum_w > MAX_W) begin
            up_val = N'(sum_w - MOD_W);
        end else begin
            up_val = N'(sum_w);
        end

        if (SAT && dn_evt) begin
            dn_val = '0;
        end else if (step_m <= cnt_w) begin
            dn_val = N'(cnt_w - step_m);
        end else begin
            dn_val = N'(cnt_w + MOD_W - step_m);
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        cout_d  = 1'b0;
        ovf_set = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (ld) begin
            if (ld_val > MAX_N) begin
                cnt_d   = MAX_N;
                ovf_set = 1'b1;
            end else begin
                cnt_d = ld_val;
            end
        end else if (en) begin
            if (up) begin
                cnt_d   = up_val;
                cout_d  = up_evt;
                ovf_set = up_evt;
            end else begin
                cnt_d   = dn_val;
                cout_d  = dn_evt;
                ovf_set = dn_evt;
            end
        end
        // A new event in the same cycle as ovf_clr keeps the flag set.
        ovf_d = ovf_set | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign cnt  = cnt_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = (cnt_q == '0);
    assign full = (cnt_q == MAX_N);

endmodule

// File: tb/tb_mod_counter_n.sv
// Bench for mod_counter_n: wrap and saturate instances (N=4,S=2,MAX=9) plus a
// default-parameter instance, checked against an arithmetic reference model.
module tb_mod_counter_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic       a_en, a_up, a_clr, a_ld, a_oc;
    logic [1:0] a_step;
    logic [3:0] a_ldv;
    logic [3:0] w_cnt, s_cnt;
    logic       w_cout, w_ovf, w_zero, w_full;
    logic       s_cout, s_ovf, s_zero, s_full;

    logic        d_en, d_up, d_clr, d_ld, d_oc;
    logic [0:0]  d_step;
    logic [10:0] d_ldv;
    logic [10:0] d_cnt;
    logic        d_cout, d_ovf, d_zero, d_full;

    mod_counter_n #(.N(4), .S(2), .MAX(9), .SAT(1'b0)) dut_w (
        .clk(clk), .rst(rst), .en(a_en), .up(a_up), .step(a_step), .clr(a_clr),
        .ld(a_ld), .ld_val(a_ldv), .ovf_clr(a_oc), .cnt(w_cnt), .cout(w_cout),
        .ovf(w_ovf), .zero(w_zero), .full(w_full));

    mod_counter_n #(.N(4), .S(2), .MAX(9), .SAT(1'b1)) dut_s (
        .clk(clk), .rst(rst), .en(a_en), .up(a_up), .step(a_step), .clr(a_clr),
        .ld(a_ld), .ld_val(a_ldv), .ovf_clr(a_oc), .cnt(s_cnt), .cout(s_cout),
        .ovf(s_ovf), .zero(s_zero), .full(s_full));

    mod_counter_n dut_d (
        .clk(clk), .rst(rst), .en(d_en), .up(d_up), .step(d_step), .clr(d_clr),
        .ld(d_ld), .ld_val(d_ldv), .ovf_clr(d_oc), .cnt(d_cnt), .cout(d_cout),
        .ovf(d_ovf), .zero(d_zero), .full(d_full));

    int n_checks = 0;
    int n_errors = 0;
    logic [14:0] exp_w_q[$];
    logic [14:0] exp_s_q[$];
    logic [14:0] exp_d_q[$];
    int mw_cnt, mw_ovf, ms_cnt, ms_ovf, md_cnt, md_ovf;

    logic [14:0] act_w, act_s, act_d;
    assign act_w = {7'd0, w_cnt, w_cout, w_ovf, w_zero, w_full};
    assign act_s = {7'd0, s_cnt, s_cout, s_ovf, s_zero, s_full};
    assign act_d = {d_cnt, d_cout, d_ovf, d_zero, d_full};

    function automatic logic [14:0] pk(input int c, input int co, input int o, input int max);
        return {11'(c), 1'(co), 1'(o), (c == 0), (c == max)};
    endfunction

    // Reference: the count lives in 0..max; moving by step either lands in range
    // or is an event (wrap modulo max+1, or clamp at the limit when saturating).
    function automatic void model(input int max, input bit sat, input int cnt, input int ovf,
                                  input bit clr, input bit ld, input int ldv, input bit en,
                                  input bit up, input int step, input bit oc,
                                  output int ncnt, output int ncout, output int novf);
        bit set;
        int t;
        set = 0;
        ncnt = cnt;
        ncout = 0;
        if (clr) begin
            ncnt = 0;
        end else if (ld) begin
            if (ldv > max) begin
                ncnt = max;
                set = 1;
            end else begin
                ncnt = ldv;
            end
        end else if (en) begin
            t = up ? cnt + step : cnt - step;
            if (t > max || t < 0) begin
                set = 1;
                ncout = 1;
                if (sat) ncnt = up ? max : 0;
                else ncnt = ((t % (max + 1)) + (max + 1)) % (max + 1);
            end else begin
                ncnt = t;
            end
        end
        novf = set ? 1 : (oc ? 0 : ovf);
    endfunction

    task automatic check_vec(input string name, input logic [14:0] act, input logic [14:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got cnt=%0d cout=%0b ovf=%0b zero=%0b full=%0b, expected cnt=%0d cout=%0b ovf=%0b zero=%0b full=%0b",
                     name, act[14:4], act[3], act[2], act[1], act[0],
                     exp[14:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: one expected vector per issued cycle, compared after the edge.
    always @(posedge clk) begin
        #1;
        if (exp_w_q.size() > 0) check_vec("sb_wrap", act_w, exp_w_q.pop_front());
        if (exp_s_q.size() > 0) check_vec("sb_sat", act_s, exp_s_q.pop_front());
        if (exp_d_q.size() > 0) check_vec("sb_default", act_d, exp_d_q.pop_front());
    end

    task automatic apply_a(input bit clr, input bit ld, input int ldv, input bit en,
                           input bit up, input int step, input bit oc);
        int nc, co, no;
        a_clr = clr; a_ld = ld; a_ldv = 4'(ldv); a_en = en; a_up = up;
        a_step = 2'(step); a_oc = oc;
        if (rst) begin
            model(9, 1'b0, mw_cnt, mw_ovf, clr, ld, ldv, en, up, step, oc, nc, co, no);
            exp_w_q.push_back(pk(nc, co, no, 9));
            mw_cnt = nc; mw_ovf = no;
            model(9, 1'b1, ms_cnt, ms_ovf, clr, ld, ldv, en, up, step, oc, nc, co, no);
            exp_s_q.push_back(pk(nc, co, no, 9));
            ms_cnt = nc; ms_ovf = no;
        end
    endtask

    task automatic drive_a(input bit clr, input bit ld, input int ldv, input bit en,
                           input bit up, input int step, input bit oc);
        @(negedge clk);
        apply_a(clr, ld, ldv, en, up, step, oc);
    endtask

    task automatic drive_d(input bit clr, input bit ld, input int ldv, input bit en,
                           input bit up, input int step, input bit oc);
        int nc, co, no;
        @(negedge clk);
        d_clr = clr; d_ld = ld; d_ldv = 11'(ldv); d_en = en; d_up = up;
        d_step = 1'(step); d_oc = oc;
        model(2047, 1'b0, md_cnt, md_ovf, clr, ld, ldv, en, up, step, oc, nc, co, no);
        exp_d_q.push_back(pk(nc, co, no, 2047));
        md_cnt = nc; md_ovf = no;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        a_en = 0; a_up = 0; a_clr = 0; a_ld = 0; a_oc = 0; a_step = '0; a_ldv = '0;
        d_en = 0; d_up = 0; d_clr = 0; d_ld = 0; d_oc = 0; d_step = '0; d_ldv = '0;
        mw_cnt = 0; mw_ovf = 0; ms_cnt = 0; ms_ovf = 0; md_cnt = 0; md_ovf = 0;
        #12;
        check_vec("reset_wrap", act_w, pk(0, 0, 0, 9));
        check_vec("reset_sat", act_s, pk(0, 0, 0, 9));
        check_vec("reset_default", act_d, pk(0, 0, 0, 2047));
        @(negedge clk);
        rst = 1'b1;

        // Wrap up: 8 + 3 -> 1
        drive_a(0, 1, 8, 0, 0, 0, 0);
        drive_a(0, 0, 0, 1, 1, 3, 0);
        settle();
        chk("wrap_up_cnt", w_cnt, 1);
        chk("wrap_up_cout", w_cout, 1);
        chk("wrap_up_ovf", w_ovf, 1);
        chk("sat_up_cnt", s_cnt, 9);
        drive_a(0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("wrap_cout_one_cycle", w_cout, 0);
        chk("wrap_ovf_sticky", w_ovf, 1);

        // Borrow down with a simultaneous ovf_clr
        drive_a(0, 1, 1, 0, 0, 0, 1);
        settle();
        chk("ovf_clr", w_ovf, 0);
        drive_a(0, 0, 0, 1, 0, 3, 1);
        settle();
        chk("borrow_cnt", w_cnt, 8);
        chk("borrow_cout", w_cout, 1);
        chk("borrow_ovf_set_wins", w_ovf, 1);
        chk("sat_borrow_cnt", s_cnt, 0);

        // Saturate at MAX for three cycles, then down to 0
        drive_a(0, 1, 9, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive_a(0, 0, 0, 1, 1, 1, 0);
            settle();
            chk("sat_hold_cnt", s_cnt, 9);
            chk("sat_hold_cout", s_cout, 1);
            chk("sat_hold_full", s_full, 1);
        end
        drive_a(0, 1, 2, 0, 0, 0, 0);
        drive_a(0, 0, 0, 1, 0, 3, 0);
        settle();
        chk("sat_down_cnt", s_cnt, 0);
        chk("sat_down_zero", s_zero, 1);

        // Priority and over-range load
        drive_a(1, 1, 5, 1, 1, 1, 0);
        settle();
        chk("prio_cnt", w_cnt, 0);
        chk("prio_cout", w_cout, 0);
        drive_a(0, 0, 0, 0, 0, 0, 1);
        settle();
        chk("prio_ovf_cleared", w_ovf, 0);
        drive_a(0, 1, 12, 0, 0, 0, 0);
        settle();
        chk("ld_over_cnt", w_cnt, 9);
        chk("ld_over_ovf", w_ovf, 1);
        chk("ld_over_cout", w_cout, 0);

        // Asynchronous reset mid-cycle
        drive_a(0, 1, 7, 0, 0, 0, 0);
        settle();
        chk("pre_reset_cnt", w_cnt, 7);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_cnt", w_cnt, 0);
        chk("async_rst_ovf", w_ovf, 0);
        chk("async_rst_zero", w_zero, 1);
        chk("async_rst_full", w_full, 0);
        chk("async_rst_sat_ovf", s_ovf, 0);
        mw_cnt = 0; mw_ovf = 0; ms_cnt = 0; ms_ovf = 0;
        exp_w_q.delete();
        exp_s_q.delete();
        drive_a(0, 0, 0, 1, 1, 1, 0);
        settle();
        chk("in_reset_ignored", w_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        apply_a(0, 0, 0, 1, 1, 1, 0);
        settle();
        chk("first_edge_cnt", w_cnt, 1);

        // Random traffic on the MAX=9 pair
        for (int i = 0; i < 300; i++) begin
            drive_a($urandom_range(15) == 0, $urandom_range(7) == 0, $urandom_range(15),
                    $urandom_range(3) != 0, $urandom_range(1) == 1, $urandom_range(3),
                    $urandom_range(7) == 0);
        end
        drive_a(0, 0, 0, 0, 0, 0, 0);

        // Default parameters: 2046 -> 2047 -> 0
        drive_d(0, 1, 2046, 0, 0, 0, 0);
        drive_d(0, 0, 0, 1, 1, 1, 0);
        settle();
        chk("default_full_cnt", d_cnt, 2047);
        chk("default_full", d_full, 1);
        drive_d(0, 0, 0, 1, 1, 1, 0);
        settle();
        chk("default_wrap_cnt", d_cnt, 0);
        chk("default_wrap_cout", d_cout, 1);
        chk("default_wrap_zero", d_zero, 1);
        for (int i = 0; i < 100; i++) begin
            drive_d($urandom_range(31) == 0, $urandom_range(7) == 0,
                    ($urandom_range(1) == 1) ? $urandom_range(2047) : $urandom_range(2047, 2040),
                    $urandom_range(3) != 0, $urandom_range(1) == 1, $urandom_range(1),
                    $urandom_range(7) == 0);
        end
        drive_d(0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #3;
        n_checks++;
        if (exp_w_q.size() + exp_s_q.size() + exp_d_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending, expected 0",
                     exp_w_q.size() + exp_s_q.size() + exp_d_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mod_counter_n.md
MOD_COUNTER_N -- requirements
Module: mod_counter_n

Interface
REQ-001 The block SHALL have parameter N, default 11: counter width in bits (N >= 2).
REQ-002 The block SHALL have parameter S, default 1: step width in bits (1 <= S <= N).
REQ-003 The block SHALL have parameter MAX, default 2**N-1: terminal count (1 <= MAX <= 2**N-1); the count range is 0..MAX.
REQ-004 The block SHALL have parameter SAT, default 0: overflow mode, where 0 = wrap (modulo MAX+1) and 1 = saturate at the limit.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port en, input, 1 bit: count enable.
REQ-008 The block SHALL have port up, input, 1 bit: direction, where 1 = increment and 0 = decrement.
REQ-009 The block SHALL have port step, input, S bits: unsigned amount added or subtracted per enabled cycle.
REQ-010 The block SHALL have port clr, input, 1 bit: synchronous clear to 0.
REQ-011 The block SHALL have port ld, input, 1 bit: synchronous load of ld_val.
REQ-012 The block SHALL have port ld_val, input, N bits: load value.
REQ-013 The block SHALL have port ovf_clr, input, 1 bit: clears the sticky ovf flag.
REQ-014 The block SHALL have port cnt, output, N bits: registered count.
REQ-015 The block SHALL have port cout, output, 1 bit: registered one-cycle pulse on a wrap, borrow or saturation event.
REQ-016 The block SHALL have port ovf, output, 1 bit: registered sticky overflow/underflow flag.
REQ-017 The block SHALL have port zero, output, 1 bit: combinational, asserted when cnt == 0.
REQ-018 The block SHALL have port full, output, 1 bit: combinational, asserted when cnt == MAX.

Function
REQ-019 The count update SHALL use the priority clr > ld > en; with none of these asserted, cnt SHALL hold.
REQ-020 clr SHALL set cnt to 0 on the next edge and SHALL not assert cout.
REQ-021 ld SHALL set cnt to ld_val on the next edge; a ld_val greater than MAX SHALL load MAX and set ovf, with cout not asserted.
REQ-022 With en=1 and up=1, the sum cnt+step SHALL be computed at N+1 bits; if the sum <= MAX, cnt SHALL take the sum.
REQ-023 With en=1 and up=1 and sum > MAX: SAT=0 SHALL set cnt to sum-(MAX+1); SAT=1 SHALL set cnt to MAX; in both modes cout SHALL pulse and ovf SHALL set.
REQ-024 With en=1 and up=0 and step <= cnt, cnt SHALL become cnt-step.
REQ-025 With en=1 and up=0 and step > cnt: SAT=0 SHALL set cnt to cnt+(MAX+1)-step; SAT=1 SHALL set cnt to 0; in both modes cout SHALL pulse and ovf SHALL set.
REQ-026 A step value greater than MAX+1 SHALL be treated as step modulo (MAX+1) in wrap mode, and as a saturating event in SAT=1.
REQ-027 step=0 with en=1 SHALL hold cnt and SHALL not assert cout.
REQ-028 In SAT=1, an enabled step that leaves cnt already at the limit (MAX when counting up, 0 when counting down) SHALL still pulse cout and set ovf.
REQ-029 cout SHALL be high for exactly the one cycle following the event edge and low otherwise; back-to-back events SHALL give cout high on consecutive cycles.
REQ-030 ovf SHALL remain set until ovf_clr; if a set event and ovf_clr occur in the same cycle, set SHALL win.
REQ-031 zero and full SHALL be derived from the registered cnt only, with no dependence on any input.
REQ-032 Latency from any control input to cnt, cout or ovf SHALL be exactly one clock edge.

Reset
REQ-033 rst=0 SHALL immediately, without waiting for a clock edge, force cnt=0, cout=0 and ovf=0, so that zero=1 and full=0.
REQ-034 The block SHALL ignore all inputs while rst=0; an operation in progress SHALL be discarded, not completed.
REQ-035 The first edge after rst rises SHALL be able to perform a normal update.

Verification (N=4, S=2, MAX=9 unless stated)
REQ-036 Wrap up (SAT=0): ld 8, then en=1, up=1, step=3 -> cnt 8->1, cout=1 for one cycle, ovf=1.
REQ-037 Borrow down (SAT=0): cnt=1, up=0, step=3 -> cnt=8, cout pulse; ovf_clr and a borrow in the same cycle -> ovf stays 1.
REQ-038 Saturate (SAT=1): cnt=9, up=1, step=1 for 3 cycles -> cnt stays 9, cout high for 3 cycles, full=1; then up=0, step=3 from cnt=2 -> cnt=0, zero=1.
REQ-039 Priority: clr=1, ld=1 (ld_val=5), en=1 together -> cnt=0 and no cout; then ld_val=12 with ld=1 -> cnt=9, ovf=1.
REQ-040 Async reset: assert rst=0 mid-cycle while cnt=7 -> cnt=0 and ovf=0 before the next edge; release and count up with step=1 -> cnt=1 after the first edge.
REQ-041 Default parameters (N=11, S=1, MAX=2047): en=1, up=1, step=1 from 2046 -> 2047 (full=1), then 0 with a cout pulse.
